// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared types, opcodes, ALU codes, bus codes and IR fields for control_unit
// Optional feature macro: CU_MULDIV_EN (adds T6 state and mul/div support).
package control_unit_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
`ifdef CU_MULDIV_EN
    ST_T6,
`endif
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_NOP,
    CLS_HALT,
    CLS_ALU,
    CLS_MULDIV
  } op_class_t;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_ROR  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_SHR  = 5'b01001,
    OP_SHRA = 5'b01010,
    OP_SHL  = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NOP  = 5'b11010,
    OP_HALT = 5'b11011
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_SHR  = 4'b0100,
    ALU_SHRA = 4'b0101,
    ALU_SHL  = 4'b0110,
    ALU_ROR  = 4'b0111,
    ALU_ROL  = 4'b1000,
    ALU_MUL  = 4'b1001,
    ALU_DIV  = 4'b1010
  } alu_op_t;

  // General-purpose registers are addressed on the bus as {1'b0, Rn}.
  typedef enum logic [4:0] {
    BUS_HI    = 5'b10000,
    BUS_LO    = 5'b10001,
    BUS_ZHIGH = 5'b10010,
    BUS_ZLOW  = 5'b10011,
    BUS_PC    = 5'b10100,
    BUS_MDR   = 5'b10101
  } bus_sel_t;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  function automatic logic [4:0] bus_gp(input logic [3:0] rn);
    return {1'b0, rn};
  endfunction

endpackage

// File: rtl/control_unit_cu_decode.sv
// rtl/control_unit_cu_decode.sv - combinational opcode to instruction class and ALU function decoder
// Optional feature macro: CU_MULDIV_EN (mul/div decode as CLS_MULDIV instead of CLS_ILLEGAL).
module cu_decode
  import control_unit_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic [2:0] o_class,
  output logic [3:0] o_alu_op
);

  always_comb begin
    o_class  = CLS_ILLEGAL;
    o_alu_op = 4'b0000;
    case (i_opcode)
      OP_ADD:  begin o_class = CLS_ALU; o_alu_op = ALU_ADD;  end
      OP_SUB:  begin o_class = CLS_ALU; o_alu_op = ALU_SUB;  end
      OP_AND:  begin o_class = CLS_ALU; o_alu_op = ALU_AND;  end
      OP_OR:   begin o_class = CLS_ALU; o_alu_op = ALU_OR;   end
      OP_ROR:  begin o_class = CLS_ALU; o_alu_op = ALU_ROR;  end
      OP_ROL:  begin o_class = CLS_ALU; o_alu_op = ALU_ROL;  end
      OP_SHR:  begin o_class = CLS_ALU; o_alu_op = ALU_SHR;  end
      OP_SHRA: begin o_class = CLS_ALU; o_alu_op = ALU_SHRA; end
      OP_SHL:  begin o_class = CLS_ALU; o_alu_op = ALU_SHL;  end
`ifdef CU_MULDIV_EN
      OP_MUL:  begin o_class = CLS_MULDIV; o_alu_op = ALU_MUL; end
      OP_DIV:  begin o_class = CLS_MULDIV; o_alu_op = ALU_DIV; end
`endif
      OP_NOP:  o_class = CLS_NOP;
      OP_HALT: o_class = CLS_HALT;
      default: o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute sequencer driving datapath strobes from state and IR
// Optional feature macro: CU_MULDIV_EN (mul/div with a T6 state writing HI after LO).
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        incPC,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_GP,
  output logic        MDR_read,
  output logic [3:0]  GP_addr,
  output logic [3:0]  ALU_op,
  output logic [4:0]  BusDataSelect,
  output logic        halted,
  output logic        illegal
);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  w_class;
  logic [3:0]  w_alu_op;
  logic        w_muldiv;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic        w_unused_ir;

  assign w_ra        = IR[IR_RA_MSB:IR_RA_LSB];
  assign w_rb        = IR[IR_RB_MSB:IR_RB_LSB];
  assign w_rc        = IR[IR_RC_MSB:IR_RC_LSB];
  assign w_unused_ir = ^IR[IR_RC_LSB-1:0];

  cu_decode u_decode (
    .i_opcode (IR[IR_OP_MSB:IR_OP_LSB]),
    .o_class  (w_class),
    .o_alu_op (w_alu_op)
  );

`ifdef CU_MULDIV_EN
  assign w_muldiv = (w_class == CLS_MULDIV);
`else
  assign w_muldiv = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    incPC         = 1'b0;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    MDR_read      = 1'b0;
    GP_addr       = 4'b0000;
    ALU_op        = 4'b0000;
    BusDataSelect = 5'b00000;
    halted        = 1'b0;
    illegal       = 1'b0;
    case (r_state)
      ST_IDLE: if (run) w_next = ST_T0;
      ST_T0: begin
        BusDataSelect = BUS_PC;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
        e_Z           = 1'b1;
        w_next        = ST_T1;
      end
      // PC takes Z (PC+1) only on the cycle the fetch completes.
      ST_T1: begin
        BusDataSelect = BUS_ZLOW;
        MDR_read      = 1'b1;
        e_MDR         = 1'b1;
        if (mem_ready) begin
          e_PC   = 1'b1;
          w_next = ST_T2;
        end
      end
      ST_T2: begin
        BusDataSelect = BUS_MDR;
        e_IR          = 1'b1;
        w_next        = ST_T3;
      end
      ST_T3: begin
        case (w_class)
          CLS_HALT: w_next = ST_HALT;
          CLS_NOP:  w_next = ST_T0;
          CLS_ALU: begin
            BusDataSelect = bus_gp(w_rb);
            e_Y           = 1'b1;
            w_next        = ST_T4;
          end
`ifdef CU_MULDIV_EN
          CLS_MULDIV: begin
            BusDataSelect = bus_gp(w_ra);
            e_Y           = 1'b1;
            w_next        = ST_T4;
          end
`endif
          default: begin
            illegal = 1'b1;
            w_next  = ST_T0;
          end
        endcase
      end
      ST_T4: begin
        BusDataSelect = w_muldiv ? bus_gp(w_rb) : bus_gp(w_rc);
        ALU_op        = w_alu_op;
        e_Z           = 1'b1;
        w_next        = ST_T5;
      end
      ST_T5: begin
        BusDataSelect = BUS_ZLOW;
`ifdef CU_MULDIV_EN
        if (w_muldiv) begin
          e_LO   = 1'b1;
          w_next = ST_T6;
        end else begin
          GP_addr = w_ra;
          e_GP    = 1'b1;
          w_next  = ST_T0;
        end
`else
        GP_addr = w_ra;
        e_GP    = 1'b1;
        w_next  = ST_T0;
`endif
      end
`ifdef CU_MULDIV_EN
      ST_T6: begin
        BusDataSelect = BUS_ZHIGH;
        e_HI          = 1'b1;
        w_next        = ST_T0;
      end
`endif
      ST_HALT: halted = 1'b1;
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit against a cycle-sequence model
// Optional feature macro: CU_MULDIV_EN (bench expects mul/div support when defined).
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] IR;
  logic        incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, MDR_read;
  logic [3:0]  GP_addr, ALU_op;
  logic [4:0]  BusDataSelect;
  logic        halted, illegal;

  control_unit dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
    .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI),
    .e_LO(e_LO), .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP), .MDR_read(MDR_read),
    .GP_addr(GP_addr), .ALU_op(ALU_op), .BusDataSelect(BusDataSelect),
    .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, MDR_read;
    logic [3:0] gp;
    logic [3:0] alu;
    logic [4:0] bus;
    logic       halted, illegal;
  } vec_t;

`ifdef CU_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  vec_t  act, exp_v;
  bit    exp_valid = 1'b0;
  string exp_tag = "";
  int    n_tests = 0;
  int    n_fail = 0;
  int    alu_map [logic [4:0]];

  vec_t  q_exp [$];
  bit    q_mr  [$];
  string q_tag [$];

  assign act = {incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, MDR_read,
                GP_addr, ALU_op, BusDataSelect, halted, illegal};

  always @(negedge clock) begin
    if (exp_valid) begin
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (IR=%h)", exp_tag, act, exp_v, IR);
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL pin_%s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic void push(input vec_t v, input bit mr, input string tag);
    q_exp.push_back(v);
    q_mr.push_back(mr);
    q_tag.push_back(tag);
  endfunction

  // Expected per-cycle outputs of one instruction, from T0 up to its last state.
  function automatic void build(input logic [31:0] ir, input int waits);
    vec_t v;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    q_exp.delete(); q_mr.delete(); q_tag.delete();
    v = '0; v.bus = 5'b10100; v.e_MAR = 1; v.incPC = 1; v.e_Z = 1;
    push(v, 1'($urandom), "T0");
    v = '0; v.bus = 5'b10011; v.MDR_read = 1; v.e_MDR = 1;
    for (int w = 0; w < waits; w++) push(v, 1'b0, "T1_wait");
    v.e_PC = 1;
    push(v, 1'b1, "T1");
    v = '0; v.bus = 5'b10101; v.e_IR = 1;
    push(v, 1'($urandom), "T2");
    v = '0;
    if (op == 5'b11011) begin
      push(v, 1'($urandom), "T3_halt");
    end else if (op == 5'b11010) begin
      push(v, 1'($urandom), "T3_nop");
    end else if (alu_map.exists(op) && (op == 5'b01111 || op == 5'b10000)) begin
      v.bus = {1'b0, ra}; v.e_Y = 1;                      push(v, 1'($urandom), "T3_md");
      v = '0; v.bus = {1'b0, rb}; v.alu = 4'(alu_map[op]); v.e_Z = 1;
      push(v, 1'($urandom), "T4_md");
      v = '0; v.bus = 5'b10011; v.e_LO = 1;                push(v, 1'($urandom), "T5_md");
      v = '0; v.bus = 5'b10010; v.e_HI = 1;                push(v, 1'($urandom), "T6_md");
    end else if (alu_map.exists(op)) begin
      v.bus = {1'b0, rb}; v.e_Y = 1;                      push(v, 1'($urandom), "T3_alu");
      v = '0; v.bus = {1'b0, rc}; v.alu = 4'(alu_map[op]); v.e_Z = 1;
      push(v, 1'($urandom), "T4_alu");
      v = '0; v.bus = 5'b10011; v.gp = ra; v.e_GP = 1;    push(v, 1'($urandom), "T5_alu");
    end else begin
      v.illegal = 1;                                       push(v, 1'($urandom), "T3_illegal");
    end
  endfunction

  task automatic step(input vec_t e, input string tag, input bit r, input bit mr, input bit clr);
    exp_v = e; exp_tag = tag; exp_valid = 1'b1;
    run = r; mem_ready = mr; clear = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_start();
    step('0, "idle_hold", 1'b0, 1'($urandom), 1'b0);
    step('0, "idle_run", 1'b1, 1'($urandom), 1'b0);
  endtask

  // abort_at: -1 none, -2 pick a random cycle of the instruction to assert clear in.
  task automatic instr(input logic [31:0] ir, input int waits, input int abort_at);
    vec_t hv;
    int   ab;
    IR = ir;
    build(ir, waits);
    ab = (abort_at == -2) ? int'($urandom_range(0, q_exp.size() - 1)) : abort_at;
    for (int i = 0; i < q_exp.size(); i++) begin
      step(q_exp[i], q_tag[i], 1'($urandom), q_mr[i], i == ab);
      if (i == ab) begin
        idle_start();
        return;
      end
    end
    if (ir[31:27] == 5'b11011) begin
      hv = '0; hv.halted = 1;
      for (int k = 0; k < 4; k++) step(hv, "halt", 1'($urandom), 1'($urandom), 1'b0);
      step(hv, "halt_clear", 1'b1, 1'($urandom), 1'b1);
      idle_start();
    end
  endtask

  logic [4:0] op_list [0:14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                 5'b10000, 5'b11010, 5'b11111, 5'b00000, 5'b01100};

  initial begin
    vec_t       lv;
    int         cnt;
    logic [31:0] ir;
    logic [4:0]  op;

    alu_map[5'b00011] = 2;  alu_map[5'b00100] = 3;  alu_map[5'b00101] = 0;
    alu_map[5'b00110] = 1;  alu_map[5'b00111] = 7;  alu_map[5'b01000] = 8;
    alu_map[5'b01001] = 4;  alu_map[5'b01010] = 5;  alu_map[5'b01011] = 6;
    if (MULDIV_EN) begin
      alu_map[5'b01111] = 9; alu_map[5'b10000] = 10;
    end

    build(32'h2A2B8000, 0);
    pin("and_len", q_exp.size(), 6);
    lv = '0; lv.bus = 5'b00101; lv.e_Y = 1;                 pin("and_T3", q_exp[3], lv);
    lv = '0; lv.bus = 5'b00111; lv.alu = 4'b0000; lv.e_Z = 1; pin("and_T4", q_exp[4], lv);
    lv = '0; lv.bus = 5'b10011; lv.gp = 4'b0100; lv.e_GP = 1; pin("and_T5", q_exp[5], lv);
    build(32'hD0000000, 3);
    pin("nop_len", q_exp.size(), 7);
    cnt = 0;
    foreach (q_exp[i]) cnt += q_exp[i].MDR_read;
    pin("nop_mdr_read_cycles", cnt, 4);
    pin("nop_epc_wait", q_exp[3].e_PC, 0);
    pin("nop_epc_last", q_exp[4].e_PC, 1);
    build(32'hF8000000, 0);
    pin("illegal_len", q_exp.size(), 4);
    pin("illegal_T3", q_exp[3].illegal, 1);
    build({5'b01111, 4'd2, 4'd5, 19'd0}, 0);
    if (MULDIV_EN) begin
      pin("mul_len", q_exp.size(), 7);
      pin("mul_T3_bus", q_exp[3].bus, 5'b00010);
      pin("mul_T4_alu", q_exp[4].alu, 4'b1001);
      pin("mul_T6_bus", q_exp[6].bus, 5'b10010);
    end else begin
      pin("mul_len", q_exp.size(), 4);
      pin("mul_illegal", q_exp[3].illegal, 1);
    end

    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; IR = 32'h0;
    @(posedge clock);
    #1;
    step('0, "reset", 1'b1, 1'b1, 1'b1);
    step('0, "reset2", 1'b1, 1'b1, 1'b1);
    idle_start();

    instr(32'h2A2B8000, 0, -1);
    instr(32'hD0000000, 3, -1);
    instr(32'hF8000000, 0, -1);
    instr({5'b01111, 4'd2, 4'd5, 19'd0}, 1, -1);
    instr({5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 4);
    instr(32'h18000000, 2, 2);
    instr(32'hD8000000, 0, -1);

    for (int n = 0; n < 200; n++) begin
      ir = $urandom;
      op = ($urandom_range(0, 29) == 0) ? 5'b11011 : op_list[$urandom_range(0, 14)];
      ir[31:27] = op;
      instr(ir, int'($urandom_range(0, 3)), ($urandom_range(0, 14) == 0) ? -2 : -1);
    end

    exp_valid = 1'b0;
    @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
